// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types and BCD helper for the score keeper
package score_pkg;

    typedef enum logic [1:0] {
        S_LIVE  = 2'b00,
        S_CHECK = 2'b01,
        S_DONE  = 2'b10
    } sk_state_t;

    typedef enum logic [1:0] {
        P_NONE  = 2'b00,
        P_WHITE = 2'b01,
        P_BLACK = 2'b10
    } player_t;

    localparam int MAX_DIGITS = 8;

    // Packed BCD (digit 0 in the LS nibble) to binary; callers zero-extend narrower scores.
    function automatic logic [31:0] bcd2bin(input logic [4*MAX_DIGITS-1:0] bcd);
        logic [31:0] acc;
        acc = '0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            acc = acc * 32'd10 + 32'(bcd[4*i +: 4]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - round-result inputs and score/match outputs of the score keeper
interface score_keeper_if #(
    parameter int DIGITS = 2
);
    logic                  add;
    logic                  whitewon;
    logic                  blackwon;
    logic                  clear_scores;
    logic [4*DIGITS-1:0]   white_score;
    logic [4*DIGITS-1:0]   black_score;
    logic                  score_event;
    logic                  flash;
    logic                  match_over;
    logic [1:0]            match_winner;
    logic                  result_err;

    modport master (
        output add, whitewon, blackwon, clear_scores,
        input  white_score, black_score, score_event, flash,
               match_over, match_winner, result_err
    );

    modport slave (
        input  add, whitewon, blackwon, clear_scores,
        output white_score, black_score, score_event, flash,
               match_over, match_winner, result_err
    );
endinterface

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - multi-digit BCD up-counter that saturates at all nines
module bcd_counter #(
    parameter int DIGITS = 2
) (
    input  logic                Clk,
    input  logic                reset_n,
    input  logic                clr,
    input  logic                inc,
    output logic [4*DIGITS-1:0] q,
    output logic                sat
);

    logic [4*DIGITS-1:0] q_inc;

    always_comb begin : ripple
        logic carry;
        carry = 1'b1;
        q_inc = q;
        sat   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (q[4*i +: 4] != 4'd9) sat = 1'b0;
            if (carry) begin
                if (q[4*i +: 4] == 4'd9) begin
                    q_inc[4*i +: 4] = 4'd0;
                end else begin
                    q_inc[4*i +: 4] = q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && !sat) begin
            q <= q_inc;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - BCD win tally, match detection and post-round flash timer
module score_keeper
    import score_pkg::*;
#(
    parameter int DIGITS       = 2,
    parameter int WIN_TARGET   = 5,
    parameter int FLASH_CYCLES = 25_000_000
) (
    input  logic          Clk,
    input  logic          reset_n,
    score_keeper_if.slave sk
);

    localparam int SW = 4 * DIGITS;
    localparam int BW = $clog2(10 ** DIGITS);
    localparam int CW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

    sk_state_t      state, next_state;
    player_t        winner_q, winner_nxt;
    logic           add_q, evt, fire;
    logic           pend, set_pend;
    logic [1:0]     pend_res;
    logic           err_q, set_err;
    logic           inc_white, inc_black;
    logic           rw, rb;
    logic           score_event_q;
    logic [CW-1:0]  flash_ctr;
    logic [SW-1:0]  w_q, b_q;
    logic           w_sat, b_sat;
    logic [BW-1:0]  white_bin, black_bin;
    logic           white_reached, black_reached;

    assign evt = sk.add & ~add_q;

    bcd_counter #(.DIGITS(DIGITS)) u_white (
        .Clk     (Clk),
        .reset_n (reset_n),
        .clr     (sk.clear_scores),
        .inc     (inc_white),
        .q       (w_q),
        .sat     (w_sat)
    );

    bcd_counter #(.DIGITS(DIGITS)) u_black (
        .Clk     (Clk),
        .reset_n (reset_n),
        .clr     (sk.clear_scores),
        .inc     (inc_black),
        .q       (b_q),
        .sat     (b_sat)
    );

    // A saturated counter is necessarily at or past any legal target.
    assign white_bin     = BW'(bcd2bin(32'(w_q)));
    assign black_bin     = BW'(bcd2bin(32'(b_q)));
    assign white_reached = w_sat | (white_bin >= BW'(WIN_TARGET));
    assign black_reached = b_sat | (black_bin >= BW'(WIN_TARGET));

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) state <= S_LIVE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        winner_nxt = winner_q;
        inc_white  = 1'b0;
        inc_black  = 1'b0;
        set_err    = 1'b0;
        set_pend   = 1'b0;
        fire       = evt | pend;
        rw         = pend ? pend_res[0] : sk.whitewon;
        rb         = pend ? pend_res[1] : sk.blackwon;
        if (sk.clear_scores) begin
            next_state = S_LIVE;
        end else begin
            case (state)
                S_LIVE: begin
                    if (fire) begin
                        if (rw && !rb) begin
                            inc_white  = 1'b1;
                            next_state = S_CHECK;
                        end else if (rb && !rw) begin
                            inc_black  = 1'b1;
                            next_state = S_CHECK;
                        end else begin
                            set_err = 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (white_reached) begin
                        winner_nxt = P_WHITE;
                        next_state = S_DONE;
                    end else if (black_reached) begin
                        winner_nxt = P_BLACK;
                        next_state = S_DONE;
                    end else begin
                        next_state = S_LIVE;
                        set_pend   = evt;
                    end
                end
                default: next_state = S_DONE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            add_q         <= 1'b0;
            pend          <= 1'b0;
            pend_res      <= 2'b00;
            err_q         <= 1'b0;
            winner_q      <= P_NONE;
            flash_ctr     <= '0;
            score_event_q <= 1'b0;
        end else begin
            add_q         <= sk.add;
            score_event_q <= inc_white | inc_black;
            if (sk.clear_scores) begin
                pend      <= 1'b0;
                err_q     <= 1'b0;
                winner_q  <= P_NONE;
                flash_ctr <= '0;
            end else begin
                pend     <= set_pend;
                if (set_pend) pend_res <= {sk.blackwon, sk.whitewon};
                if (set_err)  err_q    <= 1'b1;
                winner_q <= winner_nxt;
                // The pulse cycle itself is one flash cycle, so load one less.
                if (score_event_q)         flash_ctr <= CW'(FLASH_CYCLES - 1);
                else if (flash_ctr != '0)  flash_ctr <= flash_ctr - CW'(1);
            end
        end
    end

    assign sk.white_score  = w_q;
    assign sk.black_score  = b_q;
    assign sk.score_event  = score_event_q;
    assign sk.flash        = (flash_ctr != '0) | score_event_q;
    assign sk.match_over   = (state == S_DONE);
    assign sk.match_winner = winner_q;
    assign sk.result_err   = err_q;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - scoreboard bench for score_keeper
module tb_score_keeper;

    logic Clk = 1'b0;
    logic reset_n;
    always #5 Clk = ~Clk;

    score_keeper_if #(.DIGITS(2)) ia ();
    score_keeper_if #(.DIGITS(2)) ib ();

    score_keeper #(.DIGITS(2), .WIN_TARGET(5), .FLASH_CYCLES(8)) dut_a (
        .Clk     (Clk),
        .reset_n (reset_n),
        .sk      (ia)
    );

    score_keeper #(.DIGITS(2), .WIN_TARGET(99), .FLASH_CYCLES(8)) dut_b (
        .Clk     (Clk),
        .reset_n (reset_n),
        .sk      (ib)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int wa = 0, ba = 0, bb = 0, fc;
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic round_a(input logic w, input logic b, input bit counts);
        ia.whitewon = w;
        ia.blackwon = b;
        if (counts) begin
            if (w) wa++;
            else   ba++;
            exp_a.push_back({bcd8(wa), bcd8(ba)});
        end
        ia.add = 1'b1;
        tick();
        ia.add = 1'b0;
        tick();
    endtask

    always @(negedge Clk) begin
        if (reset_n && ia.score_event) begin
            if (exp_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_unexpected_event: score_event=1 required 0 (score %h/%h)",
                         ia.white_score, ia.black_score);
            end else begin
                check("a_score", 32'({ia.white_score, ia.black_score}), 32'(exp_a.pop_front()));
            end
        end
        if (reset_n && ib.score_event) begin
            if (exp_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_unexpected_event: score_event=1 required 0 (score %h/%h)",
                         ib.white_score, ib.black_score);
            end else begin
                check("b_score", 32'({ib.white_score, ib.black_score}), 32'(exp_b.pop_front()));
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        ia.add = 0; ia.whitewon = 0; ia.blackwon = 0; ia.clear_scores = 0;
        ib.add = 0; ib.whitewon = 0; ib.blackwon = 0; ib.clear_scores = 0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        check("rst_white", 32'(ia.white_score), 32'h00);
        check("rst_black", 32'(ia.black_score), 32'h00);
        check("rst_flash", 32'(ia.flash), 32'd0);
        check("rst_event", 32'(ia.score_event), 32'd0);
        check("rst_over", 32'(ia.match_over), 32'd0);
        check("rst_winner", 32'(ia.match_winner), 32'd0);
        check("rst_err", 32'(ia.result_err), 32'd0);

        // add held four cycles counts once; flash lasts exactly 8 cycles
        ia.whitewon = 1'b1;
        ia.blackwon = 1'b0;
        wa = 1;
        exp_a.push_back({bcd8(wa), bcd8(ba)});
        ia.add = 1'b1;
        fc = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            if (ia.flash) fc++;
            tick();
            if (i == 3) ia.add = 1'b0;
        end
        check("flash_len", 32'(fc), 32'd8);
        check("held_white", 32'(ia.white_score), 32'h01);

        // Tied and empty results flag an error without counting
        round_a(1'b1, 1'b1, 1'b0);
        check("err_set", 32'(ia.result_err), 32'd1);
        check("err_white", 32'(ia.white_score), 32'h01);
        check("err_black", 32'(ia.black_score), 32'h00);
        round_a(1'b0, 1'b0, 1'b0);
        check("err_sticky", 32'(ia.result_err), 32'd1);
        ia.clear_scores = 1'b1;
        tick();
        ia.clear_scores = 1'b0;
        wa = 0;
        ba = 0;
        check("clr_err", 32'(ia.result_err), 32'd0);
        check("clr_white", 32'(ia.white_score), 32'h00);

        // Clear and add edge in the same cycle: clear wins
        ia.whitewon = 1'b1;
        ia.blackwon = 1'b0;
        ia.clear_scores = 1'b1;
        ia.add = 1'b1;
        tick();
        ia.clear_scores = 1'b0;
        tick();
        ia.add = 1'b0;
        tick();
        tick();
        check("clr_add_white", 32'(ia.white_score), 32'h00);

        // Five white rounds take the match
        for (int i = 0; i < 4; i++) round_a(1'b1, 1'b0, 1'b1);
        check("four_white", 32'(ia.white_score), 32'h04);
        check("four_over", 32'(ia.match_over), 32'd0);
        wa = 5;
        exp_a.push_back({bcd8(wa), bcd8(ba)});
        ia.add = 1'b1;
        @(negedge Clk);
        check("win_over_t0", 32'(ia.match_over), 32'd0);
        tick();
        ia.add = 1'b0;
        @(negedge Clk);
        check("win_over_t1", 32'(ia.match_over), 32'd0);
        tick();
        @(negedge Clk);
        check("win_over_t2", 32'(ia.match_over), 32'd1);
        check("win_winner", 32'(ia.match_winner), 32'h1);
        check("win_white", 32'(ia.white_score), 32'h05);
        round_a(1'b1, 1'b0, 1'b0);
        check("done_white", 32'(ia.white_score), 32'h05);
        check("done_over", 32'(ia.match_over), 32'd1);

        // Asynchronous reset mid-flash clears everything at once
        @(negedge Clk);
        check("pre_rst_flash", 32'(ia.flash), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_white", 32'(ia.white_score), 32'h00);
        check("arst_flash", 32'(ia.flash), 32'd0);
        check("arst_over", 32'(ia.match_over), 32'd0);
        check("arst_winner", 32'(ia.match_winner), 32'd0);
        check("arst_err", 32'(ia.result_err), 32'd0);
        tick();
        reset_n = 1'b1;
        wa = 0;
        ba = 0;
        tick();

        // Black runs to 99 at back-to-back rounds; BCD carry checked at ten
        ib.whitewon = 1'b0;
        ib.blackwon = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            if (k <= 99) begin
                bb = k;
                exp_b.push_back({8'h00, bcd8(bb)});
            end
            ib.add = 1'b1;
            tick();
            ib.add = 1'b0;
            tick();
            if (k == 10) check("carry_10", 32'(ib.black_score), 32'h10);
        end
        tick();
        check("b_black_99", 32'(ib.black_score), 32'h99);
        check("b_white", 32'(ib.white_score), 32'h00);
        check("b_over", 32'(ib.match_over), 32'd1);
        check("b_winner", 32'(ib.match_winner), 32'h2);

        tick();
        tick();
        check("sb_a_drain", 32'(exp_a.size()), 32'd0);
        check("sb_b_drain", 32'(exp_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
